// File: rtl/std_arb_pkg.sv
// Shared types and helpers for round-robin shared-resource arbiters.
// Holds the sequencer state encoding and the wrap-around pointer increment.
package std_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  // Advance a round-robin pointer by one, wrapping at n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/std_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
// Zero latency; valid is low when no request is set.
module std_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k cannot overflow before the wrap.
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin go/done arbiter sharing one std_mem_d1 port among NUM_REQ requesters.
// Read done on cycle 3, write done the cycle after mem_done; requesters hold go until done.
module std_mem_d1_arbiter
  import std_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = 32,
  parameter  int IDX_SIZE = 4,
  localparam int REQ_IDX  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          go,
  input  logic [NUM_REQ-1:0]          is_write,
  input  logic [NUM_REQ*IDX_SIZE-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]    write_data,
  output logic [WIDTH-1:0]            read_data,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic [REQ_IDX-1:0]          grant_idx,
  output logic [IDX_SIZE-1:0]         mem_addr0,
  output logic [WIDTH-1:0]            mem_write_data,
  output logic                        mem_write_en,
  input  logic [WIDTH-1:0]            mem_read_data,
  input  logic                        mem_done
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [REQ_IDX-1:0] rr_ptr;
  logic               pick_vld;
  logic [REQ_IDX-1:0] pick_idx;

  std_rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (go),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = is_write[pick_idx] ? WRITE : READ;
        end
      end
      READ:    state_nxt = DONE;
      WRITE:   state_nxt = WAIT;
      WAIT:    if (mem_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a register loaded from the next state, so each output
  // lines up with the state it belongs to without combinational paths out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      grant_idx      <= '0;
      done           <= '0;
      read_data      <= '0;
      busy           <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr0      <= '0;
      mem_write_data <= '0;
    end else begin
      busy         <= (state_nxt != IDLE);
      mem_write_en <= (state_nxt == WRITE);
      done         <= (state_nxt == DONE) ? (NUM_REQ'(1) << grant_idx) : '0;
      if (state == IDLE && pick_vld) begin
        grant_idx      <= pick_idx;
        mem_addr0      <= addr[pick_idx*IDX_SIZE +: IDX_SIZE];
        mem_write_data <= write_data[pick_idx*WIDTH +: WIDTH];
      end
      if (state == READ) begin
        read_data <= mem_read_data;
      end
      if (state == DONE) begin
        rr_ptr <= REQ_IDX'(rr_next(int'(grant_idx), NUM_REQ));
      end
    end
  end

endmodule

// File: doc/std_mem_d1_arbiter.md
Name: std_mem_d1_arbiter

Overview:
- Round-robin arbiter that shares one std_mem_d1 port among NUM_REQ requesters.
- Requesters use the Calyx go/done handshake.
- Each granted access is latched, sequenced onto the memory (read capture or write-enable pulse plus wait for mem_done), then acknowledged with a one-cycle done pulse.
- Sits between compiler-generated group logic and a single-ported memory instance.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 32, data width; matches the memory WIDTH.
- IDX_SIZE, 4, address width; matches the memory IDX_SIZE.
- REQ_IDX, $clog2(NUM_REQ), width of the grant index (localparam, not overridable).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- go  input  NUM_REQ  per-requester request; held high until that requester's done
- is_write  input  NUM_REQ  per-requester op select; 1 = write, 0 = read
- addr  input  NUM_REQ*IDX_SIZE  flattened addresses; requester i at [i*IDX_SIZE +: IDX_SIZE]
- write_data  input  NUM_REQ*WIDTH  flattened write data; requester i at [i*WIDTH +: WIDTH]
- read_data  output  WIDTH  captured read result; valid in the done cycle, held until the next read capture
- done  output  NUM_REQ  one-hot, one-cycle completion pulse
- busy  output  1  high in any state other than IDLE
- grant_idx  output  REQ_IDX  index of the current or most recent grant
- mem_addr0  output  IDX_SIZE  to memory addr0
- mem_write_data  output  WIDTH  to memory write_data
- mem_write_en  output  1  to memory write_en
- mem_read_data  input  WIDTH  from memory read_data (combinational read)
- mem_done  input  1  from memory done

Behaviour:
- Reset: clk and reset are as stated above; all state and outputs are registered.
  - state = IDLE, rr_ptr = 0, grant_idx = 0.
  - done = 0, read_data = 0, busy = 0, mem_write_en = 0, mem_addr0 = 0, mem_write_data = 0.
- States: IDLE, READ, WRITE, WAIT, DONE.
- IDLE:
  - If any go bit is high, select the first set bit searching upward from rr_ptr with wrap-around (NUM_REQ-1 wraps to 0).
  - Latch grant_idx, that requester's addr, write_data and is_write.
  - Next state is WRITE if is_write is set, otherwise READ.
  - If no go bit is high, stay in IDLE.
- READ (1 cycle):
  - mem_addr0 = latched addr; mem_write_en = 0.
  - read_data <= mem_read_data; next state DONE.
- WRITE (1 cycle): mem_write_en = 1 with the latched addr and data; next state WAIT.
- WAIT:
  - mem_write_en = 0.
  - When mem_done = 1, go to DONE; otherwise stay in WAIT. There is no timeout.
- DONE (1 cycle):
  - done[grant_idx] = 1.
  - rr_ptr <= (grant_idx+1) mod NUM_REQ; next state IDLE.
  - go is not sampled in this cycle.
- Latency from go sampled high in IDLE:
  - Read: done on the 3rd cycle (IDLE, READ, DONE).
  - Write: done on the 4th cycle (IDLE, WRITE, WAIT, DONE), given mem_done one cycle after write_en.
- Back-to-back: the cycle after DONE is IDLE and may grant immediately. If the same requester's go is still high, it is treated as a new request, subject to round-robin order.
- Fairness: a requester waits at most NUM_REQ-1 other grants.
- Latching: addr and write_data changes after the grant are ignored. go dropping mid-operation does not abort the operation, and done still pulses.
- Simultaneous go bits: only one grant; the others wait with no loss.
- Reset mid-operation: the operation is abandoned and done is not pulsed. If WRITE was already issued, the memory write may still land.
- Out-of-range addresses pass through unchecked; the memory's own check reports them.
- mem_addr0 and mem_write_data hold the latched values outside IDLE and hold their last value in IDLE.

Decomposition:
- Package std_arb_pkg holds:
  - the state enum arb_state_t {IDLE, READ, WRITE, WAIT, DONE};
  - the function rr_next(ptr, n) for the wrap increment.
- Sub-module std_rr_picker (parameter N): combinational.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx (first set bit at or above ptr, wrapping).
  - Reusable by other shared-resource arbiters.

Test Plan:
1. Single read: mem[5] = 0xDEAD, go[2] = 1, is_write[2] = 0, addr2 = 5 -> done[2] high on cycle 3, read_data = 0xDEAD, grant_idx = 2, rr_ptr becomes 3.
2. Single write: go[0] = 1, is_write[0] = 1, addr0 = 3, data = 0x1234 -> mem_write_en high exactly one cycle, done[0] on cycle 4, subsequent read of 3 returns 0x1234.
3. Contention/round-robin: go = 4'b1111 held, each dropped the cycle after its done -> grant order 0, 1, 2, 3. Then from rr_ptr = 1 with go = 4'b1001 -> grant 3 before 0.
4. Wrap-around: rr_ptr = 3, go = 4'b0001 -> grant 0; after done, rr_ptr = 1.
5. Reset mid-write: assert reset in WAIT -> no done pulse, state IDLE, all outputs 0 next cycle. A following go[1] read completes normally.
6. Late changes: after grant, change addr and write_data and drop go -> memory sees the latched values, done still pulses once, no re-grant.
